// File: rtl/apb_snn_cfg_slave.sv
// APB completer for the SNN core configuration/status register bank.
// Programmable wait states on PREADY; exports config fields and a start pulse,
// collects busy/done/spike events from the core.
// Optional: define SNN_APB_PSLVERR_EN to add the pslverr response output.
module apb_snn_cfg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] THR_RST     = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        spike_in,
  input  logic        busy_in,
  input  logic        done_in,
  output logic        cfg_enable,
  output logic        cfg_start,
  output logic [15:0] cfg_threshold,
  output logic [7:0]  cfg_leak
`ifdef SNN_APB_PSLVERR_EN
  ,
  output logic        pslverr
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_e;

  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        enable_q, enable_d;
  logic        start_q, start_d;
  logic [15:0] thr_q, thr_d;
  logic [7:0]  leak_q, leak_d;
  logic [31:0] spike_cnt_q, spike_cnt_d;
  logic        done_q, done_d;
  logic [31:0] scratch_q, scratch_d;

  logic        hit;
  logic [5:0]  off;
  logic        sel_ctrl, sel_status, sel_thr, sel_leak, sel_spk, sel_scratch, mapped;
  logic        wr, soft_clr, w1c;
  logic [31:0] rdata;
  logic        unused_paddr;

  assign hit          = (paddr[31:8] == BASE_ADDR[31:8]);
  assign off          = paddr[7:2];
  assign unused_paddr = ^paddr[1:0];

  assign sel_ctrl    = (off == 6'h00);
  assign sel_status  = (off == 6'h01);
  assign sel_thr     = (off == 6'h02);
  assign sel_leak    = (off == 6'h03);
  assign sel_spk     = (off == 6'h04);
  assign sel_scratch = (off == 6'h05);
  assign mapped      = hit && (off <= 6'h05);

  // Transfer FSM: IDLE -> [WAIT x WAIT_STATES] -> READY -> IDLE
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (psel && penable) begin
          wcnt_d  = '0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_READY;
        end
      end
      ST_WAIT: begin
        if (!psel)                  state_d = ST_IDLE;
        else if (wcnt_q == WS_LAST) state_d = ST_READY;
        else                        wcnt_d  = wcnt_q + 4'd1;
      end
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register updates: writes commit on the edge ending READY; core events every cycle
  always_comb begin
    wr       = (state_q == ST_READY) && psel && pwrite && hit;
    soft_clr = wr && sel_ctrl && pwdata[2];
    w1c      = wr && sel_status && pwdata[1];

    enable_d  = (wr && sel_ctrl) ? pwdata[0] : enable_q;
    start_d   = wr && sel_ctrl && pwdata[1];
    thr_d     = (wr && sel_thr) ? pwdata[15:0] : thr_q;
    leak_d    = (wr && sel_leak) ? pwdata[7:0] : leak_q;
    scratch_d = (wr && sel_scratch) ? pwdata : scratch_q;

    // A coincident done_in beats both soft_clear and W1C
    if (done_in)             done_d = 1'b1;
    else if (soft_clr || w1c) done_d = 1'b0;
    else                     done_d = done_q;

    // soft_clear beats a coincident spike; the counter saturates
    if (soft_clr)                          spike_cnt_d = '0;
    else if (spike_in && spike_cnt_q != '1) spike_cnt_d = spike_cnt_q + 32'd1;
    else                                   spike_cnt_d = spike_cnt_q;
  end

  // Read data mux, driven onto the bus only during the READY cycle of a read
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        6'h00:   rdata = {31'b0, enable_q};
        6'h01:   rdata = {30'b0, done_q, busy_in};
        6'h02:   rdata = {16'b0, thr_q};
        6'h03:   rdata = {24'b0, leak_q};
        6'h04:   rdata = spike_cnt_q;
        6'h05:   rdata = scratch_q;
        default: rdata = '0;
      endcase
    end
    prdata = ((state_q == ST_READY) && !pwrite) ? rdata : '0;
  end

  assign pready        = (state_q == ST_READY);
  assign cfg_enable    = enable_q;
  assign cfg_start     = start_q;
  assign cfg_threshold = thr_q;
  assign cfg_leak      = leak_q;

`ifdef SNN_APB_PSLVERR_EN
  assign pslverr = (state_q == ST_READY) &&
                   (!mapped || (pwrite && (sel_status || sel_spk)));
`else
  logic unused_mapped;
  assign unused_mapped = mapped;
`endif

  // State and register bank flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      enable_q    <= 1'b0;
      start_q     <= 1'b0;
      thr_q       <= THR_RST;
      leak_q      <= 8'h01;
      spike_cnt_q <= '0;
      done_q      <= 1'b0;
      scratch_q   <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      enable_q    <= enable_d;
      start_q     <= start_d;
      thr_q       <= thr_d;
      leak_q      <= leak_d;
      spike_cnt_q <= spike_cnt_d;
      done_q      <= done_d;
      scratch_q   <= scratch_d;
    end
  end

endmodule

// File: tb/tb_apb_snn_cfg_slave.sv
// Self-checking bench for apb_snn_cfg_slave with a behavioural register-bank model.
module tb_apb_snn_cfg_slave;

  localparam logic [31:0] BASE = 32'hA500_0300;
  localparam int          WS   = 3;
  localparam logic [15:0] THR  = 16'h0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        spike_in = 1'b0, busy_in = 1'b0, done_in = 1'b0;
  logic        cfg_enable, cfg_start;
  logic [15:0] cfg_threshold;
  logic [7:0]  cfg_leak;
`ifdef SNN_APB_PSLVERR_EN
  logic        pslverr;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model of the software-visible state
  logic        m_en;
  logic [15:0] m_thr;
  logic [7:0]  m_leak;
  logic [31:0] m_cnt;
  logic        m_done;
  logic [31:0] m_scratch;

  apb_snn_cfg_slave #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .THR_RST(THR)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .spike_in(spike_in), .busy_in(busy_in), .done_in(done_in),
    .cfg_enable(cfg_enable), .cfg_start(cfg_start),
    .cfg_threshold(cfg_threshold), .cfg_leak(cfg_leak)
`ifdef SNN_APB_PSLVERR_EN
    , .pslverr(pslverr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1);
  end

  task automatic m_reset();
    m_en = 0; m_thr = THR; m_leak = 8'h01; m_cnt = 0; m_done = 0; m_scratch = 0;
  endtask

  function automatic logic in_block(input logic [31:0] a);
    return a[31:8] == BASE[31:8];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] o;
    o = {a[7:2], 2'b00};
    if (!in_block(a)) return 32'h0;
    case (o)
      8'h00: return {31'b0, m_en};
      8'h04: return {30'b0, m_done, busy_in};
      8'h08: return {16'b0, m_thr};
      8'h0C: return {24'b0, m_leak};
      8'h10: return m_cnt;
      8'h14: return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_err(input logic w, input logic [31:0] a);
    logic [7:0] o;
    o = {a[7:2], 2'b00};
    return !in_block(a) || (o > 8'h14) || (w && (o == 8'h04 || o == 8'h10));
  endfunction

  function automatic logic m_start(input logic w, input logic [31:0] a, input logic [31:0] d);
    return w && in_block(a) && (a[7:2] == 6'd0) && d[1];
  endfunction

  task automatic m_commit(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic co_spike, input logic co_done);
    logic [7:0] o;
    bit cleared;
    o = {a[7:2], 2'b00};
    cleared = 0;
    if (w && in_block(a)) begin
      case (o)
        8'h00: begin
          m_en = d[0];
          if (d[2]) begin m_cnt = 0; m_done = 0; cleared = 1; end
        end
        8'h04: if (d[1]) m_done = 0;
        8'h08: m_thr = d[15:0];
        8'h0C: m_leak = d[7:0];
        8'h14: m_scratch = d;
        default: ;
      endcase
    end
    if (co_spike && !cleared && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (co_done) m_done = 1;
  endtask

  // One APB transfer; optional core events coincide with the edge ending READY.
  // lat = cycles from setup to the cycle pready is seen high (-1 if never).
  task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic co_spike, input logic co_done,
                     output logic [31:0] rd, output int lat, output logic err);
    lat = -1; rd = 'x; err = 0;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    for (int n = 1; n < 40; n++) begin
      @(negedge clk);
      if (pready === 1'b1) begin lat = n; break; end
      @(posedge clk); #1;
    end
    rd = prdata;
`ifdef SNN_APB_PSLVERR_EN
    err = pslverr;
`endif
    spike_in = co_spike; done_in = co_done;
    @(posedge clk); #1;
    psel = 0; penable = 0; spike_in = 0; done_in = 0;
    if (lat >= 0) m_commit(w, a, d, co_spike, co_done);
  endtask

  task automatic pulse(input logic s, input logic dn);
    @(posedge clk); #1; spike_in = s; done_in = dn;
    @(posedge clk); #1; spike_in = 0; done_in = 0;
    if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (dn) m_done = 1;
  endtask

  task automatic check_xfer(input string name, input logic w, input logic [31:0] a,
                            input logic [31:0] rd, input int lat, input logic err,
                            input logic [31:0] exp_rd);
    tests++;
    if (lat !== WS + 2) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, lat, WS + 2);
    end
    if (!w) begin
      tests++;
      if (rd !== exp_rd) begin
        fails++; $display("FAIL %s rdata: got %h expected %h", name, rd, exp_rd);
      end
    end
`ifdef SNN_APB_PSLVERR_EN
    tests++;
    if (err !== m_err(w, a)) begin
      fails++; $display("FAIL %s pslverr: got %b expected %b", name, err, m_err(w, a));
    end
`else
    if (err !== 1'b0) begin
      tests++; fails++; $display("FAIL %s err: got %b expected 0", name, err);
    end
`endif
  endtask

  task automatic do_read(input string name, input logic [31:0] a);
    logic [31:0] rd, exp; int lat; logic err;
    exp = m_read(a);
    apb(1'b0, a, 32'h0, 1'b0, 1'b0, rd, lat, err);
    check_xfer(name, 1'b0, a, rd, lat, err, exp);
  endtask

  task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic co_spike, input logic co_done);
    logic [31:0] rd; int lat; logic err;
    apb(1'b1, a, d, co_spike, co_done, rd, lat, err);
    check_xfer(name, 1'b1, a, rd, lat, err, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1; m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (pready !== 0 || prdata !== 0 || cfg_enable !== 0 || cfg_start !== 0 ||
        cfg_threshold !== THR || cfg_leak !== 8'h01) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b rd=%h en=%b st=%b thr=%h leak=%h expected 0 0 0 0 %h 01",
               pready, prdata, cfg_enable, cfg_start, cfg_threshold, cfg_leak, THR);
    end
    rst = 0;
    for (int i = 0; i < 6; i++) do_read("reset_read", BASE + 32'(4 * i));
    tests++;
    if (m_read(BASE + 32'h8) !== 32'h0000_0100) begin
      fails++; $display("FAIL reset_thr_model: got %h expected 00000100", m_read(BASE + 32'h8));
    end
  endtask

  task automatic test_timing();
    logic [31:0] rd; int lat; logic err;
    do_write("scratch_wr", BASE + 32'h14, 32'hDEAD_BEEF, 0, 0);
    apb(1'b0, BASE + 32'h14, 32'h0, 0, 0, rd, lat, err);
    check_xfer("scratch_rd", 1'b0, BASE + 32'h14, rd, lat, err, 32'hDEAD_BEEF);
    @(negedge clk);
    tests++;
    if (pready !== 0 || prdata !== 0) begin
      fails++; $display("FAIL post_ready_idle: got rdy=%b rd=%h expected 0 0", pready, prdata);
    end
  endtask

  task automatic test_ctrl_start();
    do_write("ctrl_wr", BASE, 32'h3, 0, 0);
    @(negedge clk);
    tests++;
    if (cfg_start !== 1 || cfg_enable !== 1) begin
      fails++; $display("FAIL start_pulse: got st=%b en=%b expected 1 1", cfg_start, cfg_enable);
    end
    @(negedge clk);
    tests++;
    if (cfg_start !== 0) begin
      fails++; $display("FAIL start_width: got %b expected 0", cfg_start);
    end
    do_read("ctrl_rd", BASE);
  endtask

  task automatic test_spike();
    do_write("clr0", BASE, 32'h4, 0, 0);
    for (int i = 0; i < 10; i++) pulse(1, 0);
    do_read("spike10", BASE + 32'h10);
    do_write("clr_spike", BASE, 32'h4, 1, 0);
    do_read("spike_cleared", BASE + 32'h10);
  endtask

  task automatic test_done();
    busy_in = 0;
    pulse(0, 1);
    do_read("done_set", BASE + 32'h4);
    do_write("w1c_vs_done", BASE + 32'h4, 32'h2, 0, 1);
    do_read("done_held", BASE + 32'h4);
    do_write("w1c", BASE + 32'h4, 32'h2, 0, 0);
    do_read("done_clr", BASE + 32'h4);
    busy_in = 1;
    do_read("busy_live", BASE + 32'h4);
    busy_in = 0;
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = BASE + 32'h14; pwdata = 32'h1234_5678;
    @(posedge clk); #1; penable = 1;
    @(posedge clk); #1; psel = 0; penable = 0;
    for (int i = 0; i < WS + 3; i++) begin
      @(negedge clk); if (pready === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL abort_ready: got %0d ready cycles expected 0", seen);
    end
    do_read("abort_scratch", BASE + 32'h14);
  endtask

  task automatic test_unmapped();
    do_read("unmapped_rd", BASE + 32'h40);
    do_write("unmapped_wr", BASE + 32'h40, 32'hFFFF_FFFF, 0, 0);
    do_write("outblk_wr", (BASE ^ 32'h0001_0000) + 32'h8, 32'h0000_BEEF, 0, 0);
    do_read("outblk_rd", (BASE ^ 32'h0001_0000) + 32'h14);
    do_write("ro_status_wr", BASE + 32'h10, 32'h5555_5555, 0, 0);
    do_read("thr_untouched", BASE + 32'h8);
  endtask

  task automatic test_reset_mid();
    do_write("thr_set", BASE + 32'h8, 32'h0000_0777, 0, 0);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = BASE + 32'h8; pwdata = 32'h0000_1234;
    @(posedge clk); #1; penable = 1;
    @(posedge clk); #1;
    rst = 1; psel = 0; penable = 0;
    #1;
    m_reset();
    tests++;
    if (pready !== 0 || cfg_threshold !== THR) begin
      fails++; $display("FAIL reset_mid: got rdy=%b thr=%h expected 0 %h", pready, cfg_threshold, THR);
    end
    @(posedge clk); #1; rst = 0;
    do_read("thr_after_rst", BASE + 32'h8);
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, exp; int lat; logic err, w, cs, cd, exp_st;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 8))
        0, 1, 2, 3, 4, 5: a = BASE + {$urandom_range(0, 5), 2'b00} + 32'($urandom_range(0, 3));
        6: a = BASE + {$urandom_range(6, 63), 2'b00};
        7: a = BASE + 32'h40;
        default: a = (BASE ^ (32'h1 << $urandom_range(8, 31))) + {$urandom_range(0, 5), 2'b00};
      endcase
      w = $urandom_range(0, 1);
      d = $urandom;
      cs = ($urandom_range(0, 3) == 0);
      cd = ($urandom_range(0, 3) == 0);
      busy_in = $urandom_range(0, 1);
      exp = m_read(a);
      exp_st = m_start(w, a, d);
      apb(w, a, d, cs, cd, rd, lat, err);
      check_xfer("rand_xfer", w, a, rd, lat, err, exp);
      @(negedge clk);
      tests++;
      if (cfg_start !== exp_st || cfg_enable !== m_en || cfg_threshold !== m_thr || cfg_leak !== m_leak) begin
        fails++;
        $display("FAIL rand_cfg: got st=%b en=%b thr=%h leak=%h expected %b %b %h %h",
                 cfg_start, cfg_enable, cfg_threshold, cfg_leak, exp_st, m_en, m_thr, m_leak);
      end
      if ($urandom_range(0, 1) == 1) pulse($urandom_range(0, 1), $urandom_range(0, 1));
    end
    for (int i = 0; i < 6; i++) do_read("rand_final", BASE + 32'(4 * i));
  endtask

  initial begin
    m_reset();
    test_reset();
    test_timing();
    test_ctrl_start();
    test_spike();
    test_done();
    test_abort();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
